// File: rtl/monobit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : monobit_pkg
// Description : Shared definitions for the monobit frequency engine:
//               FSM state encoding, width helper functions and default
//               parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package monobit_pkg;

    localparam int c_default_seq_len   = 128;
    localparam int c_default_thresh    = 23;
    localparam int c_default_block_len = 8;
    localparam int c_default_blk_tol   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the ones counter: must hold the value SEQ_LEN itself.
    function automatic int calc_cw(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    // Width of the failing-block counter: must hold the number of blocks.
    function automatic int calc_bw(input int seq_len, input int block_len);
        return $clog2(seq_len / block_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/monobit_blk_cnt.sv
`default_nettype none
// ============================================================================
// Module      : monobit_blk_cnt
// Description : Block-frequency side counter. Counts ones within each block
//               of BLOCK_LEN accepted bits and counts the blocks whose ones
//               deviate from BLOCK_LEN/2 by more than BLK_TOL.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clear         - restart counting (new test)
//               accept        - bit_in is consumed this cycle
//               bit_in        - sample bit
//               fail_next     - failing-block count including the block that
//                               completes this cycle (for publishing with done)
// Revision    : 1.0 - initial release
// ============================================================================
module monobit_blk_cnt #(
    parameter int BLOCK_LEN = 8,
    parameter int BLK_TOL   = 2,
    parameter int BW        = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic          bit_in,
    output logic [BW-1:0] fail_next
);

    // One spare bit so that ones + tolerance never wraps.
    localparam int LW          = $clog2(BLOCK_LEN + 1) + 1;
    localparam int PW          = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int c_tol_clamp = (BLK_TOL > BLOCK_LEN) ? BLOCK_LEN : BLK_TOL;

    localparam logic [LW-1:0] c_half     = LW'(BLOCK_LEN / 2);
    localparam logic [LW-1:0] c_tol      = LW'(c_tol_clamp);
    localparam logic [LW-1:0] c_hi       = LW'(BLOCK_LEN / 2 + c_tol_clamp);
    localparam logic [PW-1:0] c_pos_last = PW'(BLOCK_LEN - 1);

    logic [LW-1:0] r_blk_ones;
    logic [PW-1:0] r_pos;
    logic [BW-1:0] r_fail;
    logic [LW-1:0] w_blk_ones_new;
    logic          w_blk_end;
    logic          w_blk_bad;

    assign w_blk_ones_new = r_blk_ones + LW'(bit_in);
    assign w_blk_end      = accept && (r_pos == c_pos_last);
    // |ones - half| > tol, written without signed arithmetic.
    assign w_blk_bad      = (w_blk_ones_new > c_hi) || ((w_blk_ones_new + c_tol) < c_half);
    assign fail_next      = r_fail + BW'(w_blk_end && w_blk_bad);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_blk_ones <= '0;
            r_pos      <= '0;
            r_fail     <= '0;
        end else if (accept) begin
            if (w_blk_end) begin
                r_blk_ones <= '0;
                r_pos      <= '0;
                r_fail     <= fail_next;
            end else begin
                r_blk_ones <= w_blk_ones_new;
                r_pos      <= r_pos + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/monobit_freq_engine.sv
`default_nettype none
// ============================================================================
// Module      : monobit_freq_engine
// Description : Monobit frequency test engine. Streams SEQ_LEN bits, counts
//               ones, and publishes S = 2*ones - SEQ_LEN with a pass verdict
//               |S| <= THRESH. Optional block-frequency failure count.
// Config      : `define BLOCK_FREQ_EN to include the block-frequency counter;
//               otherwise blk_fail is constant 0.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               start      - begin (or restart) a test, one-cycle pulse
//               bit_in     - sample bit, bit_valid qualifies it
//               bit_ready  - engine is accepting bits (RUN)
//               done       - one-cycle pulse, results valid
//               pass, sum, ones, blk_fail - results, held until next start
// Revision    : 1.0 - initial release
// ============================================================================
module monobit_freq_engine
    import monobit_pkg::*;
#(
    parameter  int SEQ_LEN   = c_default_seq_len,
    parameter  int THRESH    = c_default_thresh,
    parameter  int BLOCK_LEN = c_default_block_len,
    parameter  int BLK_TOL   = c_default_blk_tol,
    localparam int CW        = calc_cw(SEQ_LEN),
    localparam int BW        = calc_bw(SEQ_LEN, BLOCK_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic                 done,
    output logic                 pass,
    output logic signed [CW:0]   sum,
    output logic        [CW-1:0] ones,
    output logic        [BW-1:0] blk_fail
);

    localparam int              c_thresh_clamp = (THRESH > SEQ_LEN) ? SEQ_LEN : THRESH;
    localparam logic [CW+1:0]   c_seq_len_w    = (CW + 2)'(SEQ_LEN);
    localparam logic [CW+1:0]   c_thresh_w     = (CW + 2)'(c_thresh_clamp);
    localparam logic [CW-1:0]   c_last_idx     = CW'(SEQ_LEN - 1);

    state_t             r_state;
    logic               r_bit_ready;
    logic               r_done;
    logic               r_pass;
    logic [CW-1:0]      r_bits_seen;
    logic [CW-1:0]      r_ones_cnt;
    logic [CW-1:0]      r_ones;
    logic signed [CW:0] r_sum;
    logic [BW-1:0]      r_blk_fail;

    logic                 w_accept;
    logic                 w_last;
    logic [CW-1:0]        w_ones_final;
    logic signed [CW+1:0] w_sum_wide;
    logic [CW+1:0]        w_abs_sum;
    logic [BW-1:0]        w_blk_fail_next;

    // A start pulse always wins over a coincident bit.
    assign w_accept     = bit_valid && r_bit_ready && !start;
    assign w_last       = w_accept && (r_bits_seen == c_last_idx);
    assign w_ones_final = r_ones_cnt + CW'(bit_in);
    // 2*ones - SEQ_LEN with one guard bit so 2*SEQ_LEN never wraps.
    assign w_sum_wide   = $signed({1'b0, w_ones_final, 1'b0}) - $signed(c_seq_len_w);
    assign w_abs_sum    = w_sum_wide[CW+1] ? $unsigned(-w_sum_wide) : $unsigned(w_sum_wide);

`ifdef BLOCK_FREQ_EN
    monobit_blk_cnt #(
        .BLOCK_LEN (BLOCK_LEN),
        .BLK_TOL   (BLK_TOL),
        .BW        (BW)
    ) u_blk_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .accept    (w_accept),
        .bit_in    (bit_in),
        .fail_next (w_blk_fail_next)
    );
`else
    assign w_blk_fail_next = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_ready <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_bits_seen <= '0;
            r_ones_cnt  <= '0;
            r_ones      <= '0;
            r_sum       <= '0;
            r_blk_fail  <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // Same action from every state: (re)enter RUN with cleared
                // counters; an aborted run simply never reaches DONE.
                r_state     <= ST_RUN;
                r_bit_ready <= 1'b1;
                r_bits_seen <= '0;
                r_ones_cnt  <= '0;
                r_ones      <= '0;
                r_sum       <= '0;
                r_pass      <= 1'b0;
                r_blk_fail  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_RUN: begin
                        if (w_accept) begin
                            r_bits_seen <= r_bits_seen + 1'b1;
                            r_ones_cnt  <= w_ones_final;
                            if (w_last) begin
                                r_state     <= ST_DONE;
                                r_bit_ready <= 1'b0;
                                r_done      <= 1'b1;
                                r_ones      <= w_ones_final;
                                r_sum       <= $signed(w_sum_wide[CW:0]);
                                r_pass      <= (w_abs_sum <= c_thresh_w);
                                r_blk_fail  <= w_blk_fail_next;
                            end
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: begin
                        r_state     <= ST_IDLE;
                        r_bit_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bit_ready = r_bit_ready;
    assign done      = r_done;
    assign pass      = r_pass;
    assign sum       = r_sum;
    assign ones      = r_ones;
    assign blk_fail  = r_blk_fail;

endmodule
`default_nettype wire

// File: tb/tb_monobit_freq_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_monobit_freq_engine
// Description : Self-checking bench for monobit_freq_engine with
//               SEQ_LEN=16, THRESH=4, BLOCK_LEN=4, BLK_TOL=1. Honours
//               BLOCK_FREQ_EN for the blk_fail expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monobit_freq_engine;

    localparam int SEQ_LEN   = 16;
    localparam int THRESH    = 4;
    localparam int BLOCK_LEN = 4;
    localparam int BLK_TOL   = 1;
    localparam int CW        = monobit_pkg::calc_cw(SEQ_LEN);
    localparam int BW        = monobit_pkg::calc_bw(SEQ_LEN, BLOCK_LEN);
`ifdef BLOCK_FREQ_EN
    localparam bit c_blk_en = 1'b1;
`else
    localparam bit c_blk_en = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               bit_in = 1'b0;
    logic               bit_valid = 1'b0;
    logic               bit_ready;
    logic               done;
    logic               pass;
    logic signed [CW:0] sum;
    logic [CW-1:0]      ones;
    logic [BW-1:0]      blk_fail;

    int n_vec = 0;
    int n_err = 0;

    monobit_freq_engine #(
        .SEQ_LEN   (SEQ_LEN),
        .THRESH    (THRESH),
        .BLOCK_LEN (BLOCK_LEN),
        .BLK_TOL   (BLK_TOL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .done      (done),
        .pass      (pass),
        .sum       (sum),
        .ones      (ones),
        .blk_fail  (blk_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;     // sent MSB first
        int          e_sum;
        int          e_ones;
        int          e_pass;
        int          e_blk;    // expectation when block test is built in
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: counts straight from the bit vector.
    function automatic void model(input logic [15:0] b, output int e_ones,
                                  output int e_sum, output int e_pass, output int e_blk);
        int bo;
        e_ones = 0;
        e_blk  = 0;
        for (int k = 0; k < SEQ_LEN / BLOCK_LEN; k++) begin
            bo = 0;
            for (int j = 0; j < BLOCK_LEN; j++) bo += b[k * BLOCK_LEN + j];
            e_ones += bo;
            if (bo - BLOCK_LEN / 2 > BLK_TOL || BLOCK_LEN / 2 - bo > BLK_TOL) e_blk++;
        end
        e_sum  = 2 * e_ones - SEQ_LEN;
        e_pass = ((e_sum < 0 ? -e_sum : e_sum) <= THRESH) ? 1 : 0;
        if (!c_blk_en) e_blk = 0;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams one sequence into a running engine, checks done timing and
    // returns the results seen on the done cycle. Ends two cycles after done
    // with bit_valid held high through DONE and IDLE.
    task automatic stream(input logic [15:0] b, input bit stall,
                          output int d_sum, output int d_ones, output int d_pass, output int d_blk);
        int  i, cyc, early;
        bit  acc;
        i = 0; cyc = 0; early = 0;
        while (i < SEQ_LEN && cyc < 100) begin
            bit_valid = !(stall && (cyc % 2 == 1));
            bit_in    = b[SEQ_LEN - 1 - i];
            acc       = bit_valid && bit_ready;
            tick();
            if (acc) i++;
            if (done && i < SEQ_LEN) early++;
            cyc++;
        end
        check("bits_accepted", i, SEQ_LEN);
        check("early_done", early, 0);
        check("done_after_last", int'(done), 1);
        d_sum  = int'(sum);
        d_ones = int'(ones);
        d_pass = int'(pass);
        d_blk  = int'(blk_fail);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        check("done_one_cycle", int'(done), 0);
        check("ready_after_done", int'(bit_ready), 0);
        tick();
        check("idle_no_done", int'(done), 0);
        bit_valid = 1'b0;
    endtask

    task automatic check_results(input string tag, input int d_sum, input int d_ones,
                                 input int d_pass, input int d_blk, input int e_sum,
                                 input int e_ones, input int e_pass, input int e_blk);
        check({tag, "_sum"}, d_sum, e_sum);
        check({tag, "_ones"}, d_ones, e_ones);
        check({tag, "_pass"}, d_pass, e_pass);
        check({tag, "_blk"}, d_blk, e_blk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, int'(bit_ready), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_ones"}, int'(ones), 0);
        check({tag, "_blk"}, int'(blk_fail), 0);
    endtask

    initial begin
        vec_t tbl[8];
        int   d_sum, d_ones, d_pass, d_blk;
        int   e_sum, e_ones, e_pass, e_blk;
        logic [15:0] rb;

        tbl[0] = '{16'hFFFF,  16, 16, 0, 4};   // all ones
        tbl[1] = '{16'hAAAA,   0,  8, 1, 0};   // alternating
        tbl[2] = '{16'hFFC0,   4, 10, 1, 3};   // |S| == THRESH
        tbl[3] = '{16'hFFE0,   6, 11, 0, 3};   // |S| == THRESH+2
        tbl[4] = '{16'hF0CE,   2,  9, 1, 2};   // 1111 0000 1100 1110
        tbl[5] = '{16'h0000, -16,  0, 0, 4};   // all zeros
        tbl[6] = '{16'h003F,  -4,  6, 1, 3};   // negative boundary, pass
        tbl[7] = '{16'h001F,  -6,  5, 0, 3};   // negative boundary, fail

        // Reset state
        tick(); tick();
        check_zero_outputs("reset");
        rst = 1'b0;

        // bit_valid in IDLE has no effect
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(); tick();
        check("idle_valid_ready", int'(bit_ready), 0);
        check("idle_valid_ones", int'(ones), 0);
        bit_valid = 1'b0;

        // Table-driven directed vectors
        for (int v = 0; v < 8; v++) begin
            pulse_start();
            check("ready_after_start", int'(bit_ready), 1);
            stream(tbl[v].bits, 1'b0, d_sum, d_ones, d_pass, d_blk);
            e_blk = c_blk_en ? tbl[v].e_blk : 0;
            check_results($sformatf("tbl%0d", v), d_sum, d_ones, d_pass, d_blk,
                          tbl[v].e_sum, tbl[v].e_ones, tbl[v].e_pass, e_blk);
            // Results held after done
            check_results($sformatf("tbl%0d_hold", v), int'(sum), int'(ones), int'(pass),
                          int'(blk_fail), tbl[v].e_sum, tbl[v].e_ones, tbl[v].e_pass, e_blk);
        end

        // Stall: bit_valid toggling with 16 ones
        pulse_start();
        stream(16'hFFFF, 1'b1, d_sum, d_ones, d_pass, d_blk);
        check_results("stall", d_sum, d_ones, d_pass, d_blk, 16, 16, 0, c_blk_en ? 4 : 0);

        // Reset while results are held clears them
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero_outputs("rst_after_done");

        // start with bit_valid in IDLE: that bit is not taken
        bit_valid = 1'b1; bit_in = 1'b1;
        pulse_start();
        stream(16'h0000, 1'b0, d_sum, d_ones, d_pass, d_blk);
        check_results("start_with_valid", d_sum, d_ones, d_pass, d_blk, -16, 0, 0, c_blk_en ? 4 : 0);

        // Abort after 7 ones, then 16 zeros: one done only
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_ready", int'(bit_ready), 1);
        check("abort_no_done", int'(done), 0);
        stream(16'h0000, 1'b0, d_sum, d_ones, d_pass, d_blk);
        check_results("abort", d_sum, d_ones, d_pass, d_blk, -16, 0, 0, c_blk_en ? 4 : 0);

        // Reset mid-run after 9 bits
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("rst_mid_run");
        tick();
        check("rst_stays_idle", int'(bit_ready), 0);
        bit_valid = 1'b0;

        // start in DONE is honoured
        pulse_start();
        begin
            int k;
            k = 0;
            while (!done && k < 40) begin
                bit_valid = 1'b1; bit_in = 1'b1;
                tick();
                k++;
            end
        end
        check("done_reached", int'(done), 1);
        check("done_sum", int'(sum), 16);
        bit_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_ready", int'(bit_ready), 1);
        check("start_in_done_clear", int'(sum), 0);
        stream(16'hF0CE, 1'b0, d_sum, d_ones, d_pass, d_blk);
        check_results("after_done_start", d_sum, d_ones, d_pass, d_blk, 2, 9, 1, c_blk_en ? 2 : 0);

        // Randomized sequences against the reference model
        for (int r = 0; r < 40; r++) begin
            rb = 16'($urandom);
            model(rb, e_ones, e_sum, e_pass, e_blk);
            pulse_start();
            stream(rb, 1'($urandom_range(0, 1)), d_sum, d_ones, d_pass, d_blk);
            check_results($sformatf("rand%0d", r), d_sum, d_ones, d_pass, d_blk,
                          e_sum, e_ones, e_pass, e_blk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
